// File: rtl/bias_bank_add.sv
// Per-lane bias add with a banked bias store, saturation and optional ReLU.
// Two-stage valid/ready pipeline; counts output beats that needed saturation.
module bias_bank_add #(
    parameter int N_adder_tree = 16,
    parameter int DW           = 18,
    parameter int BW           = 18,
    parameter int N_GROUP      = 4,
    localparam int NB = N_GROUP * N_adder_tree,
    localparam int AW = (NB > 1) ? $clog2(NB) : 1,
    localparam int GW = (N_GROUP > 1) ? $clog2(N_GROUP) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       bias_we,
    input  logic [AW-1:0]              bias_addr,
    input  logic [BW-1:0]              bias_wdata,
    input  logic [GW-1:0]              grp_sel,
    input  logic                       relu_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_adder_tree*DW-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_adder_tree*DW-1:0] out_data,
    output logic [15:0]                sat_cnt,
    input  logic                       clr_sat
);

    logic signed [BW-1:0]           bias_reg [NB];
    logic [N_adder_tree*(DW+1)-1:0] sum_next;
    logic [N_adder_tree*(DW+1)-1:0] s1_sum_reg;
    logic                           s1_valid_reg;
    logic                           s1_relu_reg;
    logic [N_adder_tree*DW-1:0]     res_next;
    logic [N_adder_tree*DW-1:0]     out_data_reg;
    logic                           out_valid_reg;
    logic [N_adder_tree-1:0]        sat_vec;
    logic [15:0]                    sat_cnt_reg;
    logic                           s1_en;
    logic                           s2_en;

    assign s2_en     = !out_valid_reg || out_ready;
    assign s1_en     = !s1_valid_reg || s2_en;
    assign in_ready  = rst_n && s1_en;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign sat_cnt   = sat_cnt_reg;

    // Bias reads in stage 1 see the pre-write value when a write lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                bias_reg[i] <= '0;
            end
        end else if (bias_we && ({1'b0, bias_addr} < (AW+1)'(NB))) begin
            bias_reg[bias_addr] <= bias_wdata;
        end
    end

    for (genvar gi = 0; gi < N_adder_tree; gi++) begin : g_lane
        logic [AW-1:0]     bidx;
        logic [DW:0]       d_ext;
        logic [DW:0]       b_ext;
        logic [DW:0]       s;
        logic [DW-1:0]     clip;

        assign bidx  = AW'(grp_sel) * AW'(N_adder_tree) + AW'(gi);
        assign d_ext = {in_data[DW*gi+DW-1], in_data[DW*gi +: DW]};
        assign b_ext = {{(DW+1-BW){bias_reg[bidx][BW-1]}}, bias_reg[bidx]};
        assign sum_next[(DW+1)*gi +: DW+1] = d_ext + b_ext;

        // Overflow shows up as disagreement between the two top bits of the widened sum.
        assign s           = s1_sum_reg[(DW+1)*gi +: DW+1];
        assign sat_vec[gi] = s[DW] ^ s[DW-1];
        assign clip        = sat_vec[gi] ? {s[DW], {(DW-1){~s[DW]}}} : s[DW-1:0];
        assign res_next[DW*gi +: DW] = (s1_relu_reg && clip[DW-1]) ? '0 : clip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_relu_reg   <= 1'b0;
            s1_sum_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (s1_en) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_sum_reg  <= sum_next;
                    s1_relu_reg <= relu_en;
                end
            end
            if (s2_en) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= res_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_reg <= '0;
        end else if (clr_sat) begin
            sat_cnt_reg <= '0;
        end else if (s2_en && s1_valid_reg && (|sat_vec) && (sat_cnt_reg != 16'hFFFF)) begin
            sat_cnt_reg <= sat_cnt_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_bias_bank_add.sv
// Directed and randomized bench for bias_bank_add with an arithmetic reference model
// and a beat scoreboard; checks data, ordering, stalls, latency and the saturation count.
module tb_bias_bank_add;

    localparam int N  = 16;
    localparam int DW = 18;
    localparam int BW = 18;
    localparam int NG = 4;
    localparam int NB = NG * N;
    localparam int AW = $clog2(NB);
    localparam int GW = $clog2(NG);
    localparam int W  = N * DW;
    localparam int MAXV = (1 << (DW - 1)) - 1;
    localparam int MINV = -(1 << (DW - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bias_we = 1'b0;
    logic [AW-1:0] bias_addr = '0;
    logic [BW-1:0] bias_wdata = '0;
    logic [GW-1:0] grp_sel = '0;
    logic          relu_en = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [15:0]   sat_cnt;
    logic          clr_sat = 1'b0;

    bias_bank_add #(.N_adder_tree(N), .DW(DW), .BW(BW), .N_GROUP(NG)) dut (
        .clk(clk), .rst_n(rst_n), .bias_we(bias_we), .bias_addr(bias_addr),
        .bias_wdata(bias_wdata), .grp_sel(grp_sel), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_cnt(sat_cnt), .clr_sat(clr_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        bit           sat;
        int           acc_cyc;
        bit           lat;
    } beat_t;

    int           bias_m [NB];
    beat_t        q [$];
    int           model_sat = 0;
    int           cyc = 0;
    int           passed = 0;
    int           total = 0;
    int           failed = 0;
    bit           suppress_sat = 0;
    bit           lat_mode = 0;
    bit           prev_stall = 0;
    bit           last_acc = 0;
    logic [W-1:0] prev_data = '0;

    task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_i(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: plain integer add, clamp to the signed DW range, then ReLU.
    function automatic void model_beat(input logic [W-1:0] d, input int grp, input bit relu,
                                       output logic [W-1:0] r, output bit sat);
        logic [DW-1:0] lane;
        int            s;
        sat = 0;
        r   = '0;
        for (int i = 0; i < N; i++) begin
            lane = d[i*DW +: DW];
            s = $signed(lane) + bias_m[grp*N + i];
            if (s > MAXV) begin
                s = MAXV; sat = 1;
            end else if (s < MINV) begin
                s = MINV; sat = 1;
            end
            if (relu && s < 0) s = 0;
            r[i*DW +: DW] = s[DW-1:0];
        end
    endfunction

    // One clock: check settled outputs, update the scoreboard, advance past the edge.
    task automatic step();
        beat_t b;
        beat_t e;
        #2;
        chk_i("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
        if (prev_stall) begin
            chk_i("stall_valid", 32'(out_valid), 32'd1);
            chk_w("stall_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk_i("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk_w("out_data", out_data, e.data);
                model_sat += int'(e.sat);
                chk_i("sat_cnt", 32'(sat_cnt), 32'(model_sat));
                if (e.lat) chk_i("latency", 32'(cyc - e.acc_cyc), 32'd2);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        last_acc   = in_valid && in_ready;
        if (last_acc) begin
            model_beat(in_data, int'(grp_sel), relu_en, b.data, b.sat);
            if (suppress_sat) begin
                b.sat = 0;
                suppress_sat = 0;
            end
            b.acc_cyc = cyc;
            b.lat     = lat_mode;
            q.push_back(b);
        end
        if (bias_we && int'(bias_addr) < NB) bias_m[bias_addr] = $signed(bias_wdata);
        if (clr_sat) model_sat = 0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        in_valid = 0; bias_we = 0; out_ready = 1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr_bias(input int addr, input logic [BW-1:0] val);
        in_valid = 0; bias_we = 1; bias_addr = AW'(addr); bias_wdata = val;
        step();
        bias_we = 0;
    endtask

    task automatic send(input logic [W-1:0] d, input int grp, input bit relu);
        in_valid = 1; in_data = d; grp_sel = GW'(grp); relu_en = relu; out_ready = 1;
        step();
        in_valid = 0;
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] d;
        int sent;
        int k;
        for (int i = 0; i < NB; i++) bias_m[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_i("rst_in_ready", 32'(in_ready), 32'd0);
        chk_i("rst_out_valid", 32'(out_valid), 32'd0);
        chk_w("rst_out_data", out_data, '0);
        chk_i("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        rst_n = 1;
        lat_mode = 1;
        idle(1);

        // Group 1 lane 0 bias 0x100, data 0x50 -> 0x150, other lanes pass through
        wr_bias(1*N + 0, 18'h00100);
        d = rand_data();
        d[DW-1:0] = 18'h00050;
        send(d, 1, 0);
        idle(1);
        #2;
        chk_i("r21_valid", 32'(out_valid), 32'd1);
        chk_i("r21_lane0", 32'(out_data[DW-1:0]), 32'h150);
        chk_w("r21_lanes", out_data[W-1:DW], d[W-1:DW]);
        idle(1);

        // Positive and negative saturation
        wr_bias(0, 18'h1FFFF);
        d = '0; d[DW-1:0] = 18'h00001;
        send(d, 0, 0);
        idle(3);
        chk_i("r22_sat1", 32'(sat_cnt), 32'd1);
        wr_bias(0, 18'h20000);
        d = '0; d[DW-1:0] = 18'h3FFFF;
        send(d, 0, 0);
        idle(1);
        #2;
        chk_i("r22_lane_min", 32'(out_data[DW-1:0]), 32'h20000);
        idle(2);
        chk_i("r22_sat2", 32'(sat_cnt), 32'd2);

        // ReLU on a negative lane
        wr_bias(0, 18'h0);
        d = '0; d[DW-1:0] = 18'h3FFF0;
        send(d, 0, 1);
        send(d, 0, 0);
        idle(3);

        // Same-cycle bias write and accept: old value, then new
        wr_bias(0, 18'h00010);
        d = rand_data();
        in_valid = 1; in_data = d; grp_sel = 0; relu_en = 0; out_ready = 1;
        bias_we = 1; bias_addr = '0; bias_wdata = 18'h00020;
        step();
        bias_we = 0;
        send(d, 0, 0);
        idle(3);

        // Clear while idle, then clear colliding with a saturating beat entering stage 2
        clr_sat = 1; idle(1); clr_sat = 0;
        idle(1);
        chk_i("clr_idle", 32'(sat_cnt), 32'd0);
        wr_bias(0, 18'h1FFFF);
        d = '0; d[DW-1:0] = 18'h00001;
        suppress_sat = 1;
        send(d, 0, 0);
        clr_sat = 1; idle(1); clr_sat = 0;
        idle(3);

        // Eight beats with out_ready pattern 1,0,0,1
        lat_mode = 0;
        sent = 0;
        k = 0;
        while (sent < 8 && k < 100) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            in_valid = 1; bias_we = 0;
            in_data = rand_data(); grp_sel = GW'($urandom); relu_en = 1'($urandom);
            step();
            if (last_acc) sent++;
            k++;
        end
        in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            step();
            k++;
        end
        idle(3);
        chk_i("r24_sent", 32'(sent), 32'd8);
        chk_i("r24_drained", 32'(q.size()), 32'd0);

        // Random traffic with random backpressure and bias writes
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            in_data    = rand_data();
            grp_sel    = GW'($urandom);
            relu_en    = 1'($urandom);
            bias_we    = ($urandom_range(0, 4) == 0);
            bias_addr  = AW'($urandom);
            bias_wdata = BW'($urandom);
            step();
        end
        idle(5);
        chk_i("rand_drained", 32'(q.size()), 32'd0);

        // Reset with two beats in flight
        in_valid = 1; out_ready = 0; bias_we = 0;
        in_data = rand_data(); grp_sel = 0; relu_en = 0;
        step();
        in_data = rand_data();
        step();
        in_valid = 0;
        #1;
        rst_n = 0;
        #1;
        chk_i("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk_i("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk_i("mid_rst_sat_cnt", 32'(sat_cnt), 32'd0);
        chk_w("mid_rst_out_data", out_data, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        q.delete();
        for (int i = 0; i < NB; i++) bias_m[i] = 0;
        model_sat = 0;
        prev_stall = 0;
        idle(4);
        chk_i("post_rst_no_out", 32'(out_valid), 32'd0);
        lat_mode = 1;
        d = rand_data();
        send(d, 0, 0);
        send(d, 3, 0);
        idle(4);
        chk_i("final_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
